uart_rx: RTL and testbench

UART receiver, the receive-side counterpart of the team's UART transmit path. Takes the asynchronous serial line from the board pin, synchronises it, and recovers 8N1 frames (8E1 when parity is enabled) by sampling each bit at its midpoint. Delivers each byte on a parallel bus with a one-cycle valid strobe. Also flags framing and parity errors to downstream logic (display or loopback into the transmitter).

---
 rtl/uart_rx_if.sv | 28 ++
 rtl/uart_rx.sv | 169 ++++++++++++++++
 tb/tb_uart_rx.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receive-side bus for uart_rx: serial line in, byte plus status strobes out.
// master = the receiver itself, slave = the line driver / byte consumer.
interface uart_rx_if;
    logic       i_Rx_Serial;
    logic [7:0] o_Rx_Data;
    logic       o_Rx_DV;
    logic       o_Frame_Err;
    logic       o_Parity_Err;
    logic       o_Busy;

    modport master (
        input  i_Rx_Serial,
        output o_Rx_Data,
        output o_Rx_DV,
        output o_Frame_Err,
        output o_Parity_Err,
        output o_Busy
    );

    modport slave (
        output i_Rx_Serial,
        input  o_Rx_Data,
        input  o_Rx_DV,
        input  o_Frame_Err,
        input  o_Parity_Err,
        input  o_Busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM, 8N1 framing.
// Define UART_RX_PARITY_EN for 8E1 framing with parity-error reporting.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned HALF_BIT     = (CLKS_PER_BIT - 1) / 2
) (
    input  logic     i_Clk,
    input  logic     i_Rst_n,
    uart_rx_if.master rx_if
);

    localparam int unsigned   CntW     = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] BitTerm  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfTerm = CntW'(HALF_BIT);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StStart    = 3'd1;
    localparam logic [2:0] StData     = 3'd2;
    localparam logic [2:0] StStop     = 3'd3;
    localparam logic [2:0] StWaitHigh = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] StParity   = 3'd5;
`endif

    logic [1:0]      sync_q;
    logic            rx_s;
    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            dv_q, dv_d;
    logic            fe_q, fe_d;
`ifdef UART_RX_PARITY_EN
    logic            pe_q, pe_d;
    logic            par_bad_q, par_bad_d;
`endif

    assign rx_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        pe_d      = 1'b0;
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == HalfTerm) begin
                    cnt_d = '0;
                    idx_d = 3'd0;
                    // Line back high at mid start bit: glitch, not a frame.
                    state_d = rx_s ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == BitTerm) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (cnt_q == BitTerm) begin
                    cnt_d     = '0;
                    par_bad_d = rx_s ^ (^shift_q);
                    state_d   = StStop;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            StStop: begin
                if (cnt_q == BitTerm) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        fe_d    = 1'b1;
                        state_d = StWaitHigh;
                    end else begin
                        state_d = StIdle;
`ifdef UART_RX_PARITY_EN
                        if (par_bad_q) begin
                            pe_d = 1'b1;
                        end else begin
                            dv_d   = 1'b1;
                            data_d = shift_q;
                        end
`else
                        dv_d   = 1'b1;
                        data_d = shift_q;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitHigh: begin
                // A held-low break yields one framing error, not a stream of frames.
                if (rx_s) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync_q  <= 2'b11;
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            dv_q    <= 1'b0;
            fe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pe_q      <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            sync_q  <= {sync_q[0], rx_if.i_Rx_Serial};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            fe_q    <= fe_d;
`ifdef UART_RX_PARITY_EN
            pe_q      <= pe_d;
            par_bad_q <= par_bad_d;
`endif
        end
    end

    assign rx_if.o_Rx_Data   = data_q;
    assign rx_if.o_Rx_DV     = dv_q;
    assign rx_if.o_Frame_Err = fe_q;
    assign rx_if.o_Busy      = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
    assign rx_if.o_Parity_Err = pe_q;
`else
    assign rx_if.o_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, corner sequences, random frames vs model.
module tb_uart_rx;
    localparam int unsigned CPB  = 16;
    localparam int unsigned HALF = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
    localparam bit ParEn = 1'b1;
    localparam int NBits = 10;
`else
    localparam bit ParEn = 1'b0;
    localparam int NBits = 9;
`endif
    localparam int LatNom = 2 + 1 + int'(HALF) + NBits * int'(CPB);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_if rx_if ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clk  (clk),
        .i_Rst_n(rst_n),
        .rx_if  (rx_if)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pulses are recorded away from the active edge.
    logic [7:0] dv_data[$];
    int         dv_lat[$];
    int         fe_cnt, pe_cnt, excl_viol, busy_cycles, frame_start;
    logic       dv_prev = 1'b0;
    logic       busy_after_dv;

    always @(negedge clk) begin
        if (rx_if.o_Rx_DV === 1'b1) begin
            dv_data.push_back(rx_if.o_Rx_Data);
            dv_lat.push_back(cyc - frame_start);
        end
        if (rx_if.o_Frame_Err === 1'b1) fe_cnt++;
        if (rx_if.o_Parity_Err === 1'b1) pe_cnt++;
        if ((int'(rx_if.o_Rx_DV) + int'(rx_if.o_Frame_Err) + int'(rx_if.o_Parity_Err)) > 1)
            excl_viol++;
        if (rx_if.o_Busy === 1'b1) busy_cycles++;
        if (dv_prev) busy_after_dv = rx_if.o_Busy;
        dv_prev = rx_if.o_Rx_DV;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic clear_mon();
        dv_data.delete();
        dv_lat.delete();
        fe_cnt        = 0;
        pe_cnt        = 0;
        excl_viol     = 0;
        busy_cycles   = 0;
        busy_after_dv = 1'b1;
    endtask

    // Called at a negedge; holds the line for n cycles.
    task automatic drive_bit(input logic v, input int n);
        rx_if.i_Rx_Serial = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop,
                              input int hold_bits);
        frame_start = cyc;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
        if (ParEn) drive_bit(par_bit, CPB);
        drive_bit(stop, CPB);
        if (!stop) drive_bit(1'b0, hold_bits * CPB);
        rx_if.i_Rx_Serial = 1'b1;
    endtask

    function automatic logic even_par(input logic [7:0] d);
        return logic'($countones(d) % 2);
    endfunction

    // Reference outcome of one frame: 0 = byte delivered, 1 = framing, 2 = parity.
    function automatic int ref_outcome(input logic [7:0] d, input logic par_bit, input logic stop);
        if (!stop) return 1;
        if (ParEn && ((($countones(d) + int'(par_bit)) % 2) != 0)) return 2;
        return 0;
    endfunction

    typedef struct {
        logic [7:0] data;
        logic       par_flip;
        logic       stop;
        int         hold;
        int         exp_dv;
        int         exp_fe;
        int         exp_pe;
        logic [7:0] exp_data;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] d, input logic pf, input logic st, input int h,
                                input int dv, input int fe, input int pe, input logic [7:0] ed);
        vec_t v;
        v.data = d; v.par_flip = pf; v.stop = st; v.hold = h;
        v.exp_dv = dv; v.exp_fe = fe; v.exp_pe = pe; v.exp_data = ed;
        return v;
    endfunction

    vec_t       vecs[$];
    logic [7:0] model_data;
    logic [7:0] expect_b2b[3];

    initial begin
        rx_if.i_Rx_Serial = 1'b1;
        vecs.push_back(mk(8'hA5, 1'b0, 1'b1, 0, 1, 0, 0, 8'hA5));
        vecs.push_back(mk(8'h00, 1'b0, 1'b0, 40, 0, 1, 0, 8'hA5));
        vecs.push_back(mk(8'h3C, 1'b0, 1'b1, 0, 1, 0, 0, 8'h3C));
`ifdef UART_RX_PARITY_EN
        vecs.push_back(mk(8'h07, 1'b0, 1'b1, 0, 1, 0, 0, 8'h07));
        vecs.push_back(mk(8'h07, 1'b1, 1'b1, 0, 0, 0, 1, 8'h07));
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data", rx_if.o_Rx_Data, 8'h00);
        check("rst_dv", rx_if.o_Rx_DV, 1'b0);
        check("rst_fe", rx_if.o_Frame_Err, 1'b0);
        check("rst_pe", rx_if.o_Parity_Err, 1'b0);
        check("rst_busy", rx_if.o_Busy, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Table-driven frames
        foreach (vecs[k]) begin
            clear_mon();
            send_frame(vecs[k].data, even_par(vecs[k].data) ^ vecs[k].par_flip, vecs[k].stop,
                       vecs[k].hold);
            drive_bit(1'b1, CPB);
            check($sformatf("vec%0d_dv_cnt", k), dv_data.size(), vecs[k].exp_dv);
            check($sformatf("vec%0d_fe_cnt", k), fe_cnt, vecs[k].exp_fe);
            check($sformatf("vec%0d_pe_cnt", k), pe_cnt, vecs[k].exp_pe);
            check($sformatf("vec%0d_data", k), rx_if.o_Rx_Data, vecs[k].exp_data);
            check($sformatf("vec%0d_excl", k), excl_viol, 0);
            check($sformatf("vec%0d_busy_end", k), rx_if.o_Busy, 1'b0);
            if (vecs[k].exp_dv == 1 && dv_data.size() > 0) begin
                check($sformatf("vec%0d_dv_data", k), dv_data[0], vecs[k].data);
                check_range($sformatf("vec%0d_latency", k), dv_lat[0], LatNom - 2, LatNom + 2);
                check($sformatf("vec%0d_busy_after_dv", k), busy_after_dv, 1'b0);
            end
        end

        // Short glitch on the line
        clear_mon();
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 30);
        check("glitch_dv", dv_data.size(), 0);
        check("glitch_fe", fe_cnt, 0);
        check("glitch_pe", pe_cnt, 0);
        check("glitch_busy_short", busy_cycles <= 10, 1);
        check("glitch_busy_end", rx_if.o_Busy, 1'b0);

        // Back-to-back frames, no idle gap
        clear_mon();
        expect_b2b[0] = 8'h00; expect_b2b[1] = 8'hFF; expect_b2b[2] = 8'h81;
        for (int i = 0; i < 3; i++) send_frame(expect_b2b[i], even_par(expect_b2b[i]), 1'b1, 0);
        drive_bit(1'b1, CPB);
        check("b2b_dv_cnt", dv_data.size(), 3);
        for (int i = 0; i < 3; i++)
            if (dv_data.size() > i) check($sformatf("b2b_data%0d", i), dv_data[i], expect_b2b[i]);
        check("b2b_errs", fe_cnt + pe_cnt, 0);

        // Reset in the middle of bit 4 of 0x55
        clear_mon();
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(i % 2 == 0, CPB);
        drive_bit(1'b1, CPB / 2);
        rst_n = 1'b0;
        #1;
        check("midrst_data", rx_if.o_Rx_Data, 8'h00);
        check("midrst_busy", rx_if.o_Busy, 1'b0);
        check("midrst_dv", rx_if.o_Rx_DV, 1'b0);
        @(negedge clk);
        drive_bit(1'b1, 3);
        rst_n = 1'b1;
        drive_bit(1'b1, 2 * CPB);
        check("midrst_no_pulse", dv_data.size() + fe_cnt + pe_cnt, 0);
        clear_mon();
        send_frame(8'h12, even_par(8'h12), 1'b1, 0);
        drive_bit(1'b1, CPB);
        check("midrst_after_cnt", dv_data.size(), 1);
        check("midrst_after_data", rx_if.o_Rx_Data, 8'h12);
        model_data = 8'h12;

        // Randomised frames against the reference model
        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            logic       stop, pbit;
            int         outc;
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 5) != 0);
            pbit = even_par(d);
`ifdef UART_RX_PARITY_EN
            if ($urandom_range(0, 4) == 0) pbit = ~pbit;
`endif
            outc = ref_outcome(d, pbit, stop);
            if (outc == 0) model_data = d;
            clear_mon();
            send_frame(d, pbit, stop, int'($urandom_range(1, 3)));
            drive_bit(1'b1, int'($urandom_range(1, 3)) * CPB);
            check($sformatf("rnd%0d_dv_cnt", n), dv_data.size(), outc == 0);
            check($sformatf("rnd%0d_fe_cnt", n), fe_cnt, outc == 1);
            check($sformatf("rnd%0d_pe_cnt", n), pe_cnt, outc == 2);
            check($sformatf("rnd%0d_data", n), rx_if.o_Rx_Data, model_data);
            check($sformatf("rnd%0d_excl", n), excl_viol, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
